// File: rtl/scan_seq_ctrl_if.sv
// Handshake and panel-pin bundle between the scan sequencer and its surroundings.
// slave is the sequencer's view; master is the driving side (engines and system).
interface scan_seq_ctrl_if;
    logic       en;
    logic       vsync;
    logic       clr_req;
    logic       clr_start;
    logic       clr_done;
    logic       frm_start;
    logic       frm_done;
    logic [8:0] c_ctl;
    logic [8:0] f_ctl;
    logic [8:0] p_ctl;
    logic       busy;
    logic       err;
    logic [7:0] drop_cnt;
    logic [2:0] state;

    modport slave (
        input  en, vsync, clr_req, clr_done, frm_done, c_ctl, f_ctl,
        output clr_start, frm_start, p_ctl, busy, err, drop_cnt, state
    );

    modport master (
        output en, vsync, clr_req, clr_done, frm_done, c_ctl, f_ctl,
        input  clr_start, frm_start, p_ctl, busy, err, drop_cnt, state
    );
endinterface

// File: rtl/scan_seq_ctrl.sv
// Row-scan sequencer: shares the panel pins between the clear and frame engines,
// aligns frames to vsync, blanks between passes and watchdogs each engine run.
module scan_seq_ctrl #(
    parameter int BLANK_CYC   = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic           clk,
    input  logic           rst_n,
    scan_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLR_RUN = 3'd1,
        WAIT_VS = 3'd2,
        FRM_RUN = 3'd3,
        BLANK   = 3'd4,
        ABORT   = 3'd5
    } state_e;

    // Pin order {col_start,col_shift,lrn,g1,g2,ren,woe,row_data,spare}; only lrn high.
    localparam logic [8:0] SAFE_CTL = 9'h040;
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);
    localparam logic [15:0]   WD_LAST    = 16'(TIMEOUT_CYC - 1);

    state_e          state_q, state_d;
    logic            clr_pend_q, clr_pend_d;
    logic            clr_start_q, clr_start_d;
    logic            frm_start_q, frm_start_d;
    logic            err_q, err_d;
    logic            vsync_q;
    logic [7:0]      drop_q, drop_d;
    logic [15:0]     wd_q, wd_d;
    logic [BW-1:0]   blank_q, blank_d;
    logic [8:0]      p_ctl_q, p_ctl_d;
    logic            vs_edge;
    logic            run;

    always_comb begin
        vs_edge     = bus.vsync & ~vsync_q;
        run         = (state_q == CLR_RUN) || (state_q == FRM_RUN);
        state_d     = state_q;
        clr_pend_d  = clr_pend_q | bus.clr_req;
        clr_start_d = 1'b0;
        frm_start_d = 1'b0;
        err_d       = err_q;
        // Both counters restart from zero on every entry into their state.
        wd_d        = run ? wd_q + 16'd1 : 16'd0;
        blank_d     = (state_q == BLANK) ? blank_q + BW'(1) : '0;
        drop_d      = drop_q;
        if (vs_edge && (state_q != WAIT_VS) && (drop_q != 8'hFF))
            drop_d = drop_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    if (clr_pend_q) begin
                        state_d     = CLR_RUN;
                        clr_start_d = 1'b1;
                        clr_pend_d  = bus.clr_req;
                    end else begin
                        state_d = WAIT_VS;
                    end
                end
            end
            CLR_RUN: begin
                if (bus.clr_done) begin
                    state_d = BLANK;
                end else if (wd_q == WD_LAST) begin
                    state_d    = ABORT;
                    err_d      = 1'b1;
                    clr_pend_d = 1'b1;
                end
            end
            WAIT_VS: begin
                if (!bus.en || clr_pend_q) begin
                    state_d = IDLE;
                end else if (vs_edge) begin
                    state_d     = FRM_RUN;
                    frm_start_d = 1'b1;
                end
            end
            FRM_RUN: begin
                if (bus.frm_done) begin
                    state_d = BLANK;
                end else if (wd_q == WD_LAST) begin
                    state_d    = ABORT;
                    err_d      = 1'b1;
                    clr_pend_d = 1'b1;
                end
            end
            BLANK: begin
                if (blank_q == BLANK_LAST)
                    state_d = (bus.en && !clr_pend_q) ? WAIT_VS : IDLE;
            end
            ABORT:   state_d = BLANK;
            default: state_d = IDLE;
        endcase

        // Pins follow the running engine one cycle late; an abort snaps them safe at once.
        case (state_q)
            CLR_RUN: p_ctl_d = bus.c_ctl;
            FRM_RUN: p_ctl_d = bus.f_ctl;
            default: p_ctl_d = SAFE_CTL;
        endcase
        if (state_d == ABORT)
            p_ctl_d = SAFE_CTL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            clr_pend_q  <= 1'b1;
            clr_start_q <= 1'b0;
            frm_start_q <= 1'b0;
            err_q       <= 1'b0;
            vsync_q     <= 1'b0;
            drop_q      <= 8'd0;
            wd_q        <= 16'd0;
            blank_q     <= '0;
            p_ctl_q     <= SAFE_CTL;
        end else begin
            state_q     <= state_d;
            clr_pend_q  <= clr_pend_d;
            clr_start_q <= clr_start_d;
            frm_start_q <= frm_start_d;
            err_q       <= err_d;
            vsync_q     <= bus.vsync;
            drop_q      <= drop_d;
            wd_q        <= wd_d;
            blank_q     <= blank_d;
            p_ctl_q     <= p_ctl_d;
        end
    end

    assign bus.clr_start = clr_start_q;
    assign bus.frm_start = frm_start_q;
    assign bus.p_ctl     = p_ctl_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.err       = err_q;
    assign bus.drop_cnt  = drop_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed bench for scan_seq_ctrl: expected state/start events are queued by the
// stimulus and consumed by an independent monitor; pin routing is tracked per cycle.
module tb_scan_seq_ctrl;
    localparam int BLANK_CYC   = 16;
    localparam int TIMEOUT_CYC = 200;
    localparam logic [8:0] SAFE = 9'h040;
    localparam int EV_CS = 8;
    localparam int EV_FS = 9;

    typedef struct {
        int code;
        int dwell;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    ev_t  exp_q[$];

    scan_seq_ctrl_if bus();

    scan_seq_ctrl #(.BLANK_CYC(BLANK_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic void push(input int code, input int dwell);
        exp_q.push_back('{code, dwell});
    endfunction

    function automatic void observe(input int code, input int dwell);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL event: got unexpected event %0d expected none at %0t", code, $time);
            return;
        end
        e = exp_q.pop_front();
        check("event", code, e.code);
        if (e.dwell >= 0) check("dwell", dwell, e.dwell);
    endfunction

    // Monitor: state changes and start pulses against the queue, pins against the routing rule.
    initial begin
        logic [2:0] prev_st;
        logic [8:0] prev_c, prev_f, exp_p;
        int         dwell;
        bit         have_prev;
        have_prev = 1'b0;
        dwell     = 0;
        prev_st   = 3'd0;
        prev_c    = 9'd0;
        prev_f    = 9'd0;
        forever begin
            @(negedge clk);
            if (!mon_en || !rst_n) begin
                have_prev = 1'b0;
            end else begin
                if (have_prev) begin
                    if (bus.state == 3'd5)      exp_p = SAFE;
                    else if (prev_st == 3'd1)   exp_p = prev_c;
                    else if (prev_st == 3'd3)   exp_p = prev_f;
                    else                        exp_p = SAFE;
                    check("p_ctl", bus.p_ctl, exp_p);
                    if (bus.state != prev_st) begin
                        observe(int'(bus.state), dwell);
                        dwell = 1;
                    end else begin
                        dwell++;
                    end
                end else begin
                    dwell = 1;
                end
                if (bus.clr_start) observe(EV_CS, -1);
                if (bus.frm_start) observe(EV_FS, -1);
                prev_st   = bus.state;
                prev_c    = bus.c_ctl;
                prev_f    = bus.f_ctl;
                have_prev = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_start();
        bus.vsync = 1'b1;
        tick();
        bus.vsync = 1'b0;
    endtask

    task automatic vs_pulse();
        vs_start();
        tick();
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, input string name);
        int k = 0;
        while (bus.state !== s && k < bound) begin
            tick();
            k++;
        end
        if (k >= bound) begin
            checks++;
            errors++;
            $display("FAIL %s: state %0d never reached within %0d cycles, still %0d", name, s, bound, bus.state);
        end
    endtask

    // Engine model: wait for its start pulse, run n cycles, then a one-cycle done (n<0: never done).
    task automatic run_engine(input bit frm, input int n, input bit req);
        int k = 0;
        while (!(frm ? bus.frm_start : bus.clr_start) && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) begin
            checks++;
            errors++;
            $display("FAIL start_wait: got no %s pulse expected one within 100 cycles", frm ? "frm_start" : "clr_start");
            return;
        end
        if (req) bus.clr_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (req) bus.clr_req = 1'b0;
            if (frm) bus.f_ctl = 9'(i * 73 + 11);
            else     bus.c_ctl = 9'(i * 37 + 5);
        end
        if (n >= 0) begin
            if (frm) bus.frm_done = 1'b1;
            else     bus.clr_done = 1'b1;
            tick();
            bus.frm_done = 1'b0;
            bus.clr_done = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        bus.en = 1'b0; bus.vsync = 1'b0; bus.clr_req = 1'b0;
        bus.clr_done = 1'b0; bus.frm_done = 1'b0;
        bus.c_ctl = 9'd0; bus.f_ctl = 9'd0;

        repeat (3) tick();
        check("rst_state", bus.state, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_drop", bus.drop_cnt, 0);
        check("rst_pctl", bus.p_ctl, SAFE);
        check("rst_clr_start", bus.clr_start, 0);
        check("rst_frm_start", bus.frm_start, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick();
        check("idle_no_en", bus.state, 0);

        // Power-up clear, then blank into WAIT_VS.
        push(1, -1); push(EV_CS, -1); push(4, 41); push(2, BLANK_CYC);
        bus.en = 1'b1;
        run_engine(1'b0, 40, 1'b0);
        wait_state(3'd2, 40, "t1_wait_vs");
        check("t1_state", bus.state, 2);
        check("t1_busy", bus.busy, 1);

        // One serviced frame.
        push(3, -1); push(EV_FS, -1); push(4, 101); push(2, BLANK_CYC);
        vs_start();
        run_engine(1'b1, 100, 1'b0);
        wait_state(3'd2, 40, "t2_wait_vs");
        check("t2_drop", bus.drop_cnt, 0);

        // Three edges while the frame runs are dropped.
        push(3, -1); push(EV_FS, -1); push(4, 21); push(2, BLANK_CYC);
        vs_start();
        fork
            run_engine(1'b1, 20, 1'b0);
            begin
                repeat (3) tick();
                repeat (3) vs_pulse();
            end
        join
        wait_state(3'd2, 40, "t3_wait_vs");
        check("t3_drop3", bus.drop_cnt, 3);

        // Park in IDLE and saturate the drop counter.
        push(0, -1);
        bus.en = 1'b0;
        wait_state(3'd0, 10, "t3_idle");
        repeat (100) vs_pulse();
        check("t3_drop103", bus.drop_cnt, 103);
        repeat (200) vs_pulse();
        check("t3_drop_sat", bus.drop_cnt, 255);
        check("t3_err_clear", bus.err, 0);
        push(2, -1);
        bus.en = 1'b1;
        wait_state(3'd2, 10, "t3_rewait");

        // clr_req mid-frame, vsync during BLANK, then clr_req coincident with clr_start.
        push(3, -1); push(EV_FS, -1); push(4, 31); push(0, BLANK_CYC);
        push(1, 1); push(EV_CS, -1); push(4, 11); push(0, BLANK_CYC);
        push(1, 1); push(EV_CS, -1); push(4, 11); push(2, BLANK_CYC);
        vs_start();
        fork
            run_engine(1'b1, 30, 1'b0);
            begin
                repeat (5) tick();
                bus.clr_req = 1'b1;
                tick();
                bus.clr_req = 1'b0;
            end
            begin
                repeat (40) tick();
                vs_start();
            end
        join
        run_engine(1'b0, 10, 1'b1);
        run_engine(1'b0, 10, 1'b0);
        wait_state(3'd2, 40, "t4_wait_vs");

        // Frame engine never finishes: watchdog abort, blank, forced clear pass.
        push(3, -1); push(EV_FS, -1); push(5, TIMEOUT_CYC); push(4, 1);
        push(0, BLANK_CYC); push(1, 1); push(EV_CS, -1); push(4, 11); push(2, BLANK_CYC);
        vs_start();
        run_engine(1'b1, -1, 1'b0);
        k = 0;
        while (bus.state !== 3'd5 && k < 300) begin
            tick();
            bus.f_ctl = 9'(k * 29 + 3);
            k++;
        end
        if (k >= 300) begin
            checks++;
            errors++;
            $display("FAIL t5_abort: got state %0d expected 5 within 300 cycles", bus.state);
        end
        check("t5_err", bus.err, 1);
        check("t5_pctl_safe", bus.p_ctl, SAFE);
        run_engine(1'b0, 10, 1'b0);
        wait_state(3'd2, 40, "t5_wait_vs");
        check("t5_err_sticky", bus.err, 1);

        // en dropped mid-clear: clear completes, blank, park in IDLE.
        push(0, -1); push(1, 1); push(EV_CS, -1); push(4, 11); push(0, BLANK_CYC);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        fork
            run_engine(1'b0, 10, 1'b0);
            begin
                repeat (5) tick();
                bus.en = 1'b0;
            end
        join
        wait_state(3'd0, 40, "t6_idle");
        repeat (5) tick();
        check("t6_state", bus.state, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_err_held", bus.err, 1);
        check("t6_drop_held", bus.drop_cnt, 255);

        // Reset in the middle of a frame.
        push(2, -1); push(3, -1); push(EV_FS, -1);
        bus.en = 1'b1;
        wait_state(3'd2, 10, "t7_wait_vs");
        vs_start();
        run_engine(1'b1, -1, 1'b0);
        bus.f_ctl = 9'h1BF;
        repeat (3) tick();
        check("t7_run_pctl", bus.p_ctl, 9'h1BF);
        check("queue_empty", exp_q.size(), 0);
        mon_en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("t7_rst_pctl", bus.p_ctl, SAFE);
        check("t7_rst_state", bus.state, 0);
        check("t7_rst_busy", bus.busy, 0);
        check("t7_rst_err", bus.err, 0);
        check("t7_rst_drop", bus.drop_cnt, 0);
        check("t7_rst_frm_start", bus.frm_start, 0);
        bus.en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/scan_seq_ctrl.md
Name: scan_seq_ctrl

Overview:
- Top-level sequencer for the LED/LCD row-scan path. It owns the panel control pins and shares them between two engines: the power-up/on-demand clear engine and the per-frame scan engine.
- Launches each engine with a start pulse and waits for its done pulse.
- Aligns frame scans to vsync, inserts blanking between frames, services re-clear requests at frame boundaries, and watchdogs both engines.

Parameters:
- BLANK_CYC, 16, idle cycles with panel in safe state after every clear or frame (>=1)
- TIMEOUT_CYC, 65535, max cycles an engine may run before abort (16-bit)

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- en  in  1  sequencer enable (level)
- vsync  in  1  frame sync, synchronous, rising edge = frame request
- clr_req  in  1  one-cycle request for an extra clear pass
- clr_start  out  1  one-cycle launch pulse to clear engine
- clr_done  in  1  one-cycle completion pulse from clear engine
- frm_start  out  1  one-cycle launch pulse to frame engine
- frm_done  in  1  one-cycle completion pulse from frame engine
- c_ctl  in  9  clear-engine pins {col_start,col_shift,lrn,g1,g2,ren,woe,row_data,spare}
- f_ctl  in  9  frame-engine pins, same order
- p_ctl  out  9  registered panel pins, same order
- busy  out  1  high in any state except IDLE
- err  out  1  sticky watchdog-abort flag
- drop_cnt  out  8  saturating count of vsync edges not serviced
- state  out  3  current FSM state encoding

Behaviour:
- Reset values: FSM IDLE; clr_start=0; frm_start=0; busy=0; err=0; drop_cnt=0; clr_pend=1 (power-up clear is mandatory).
- Reset value of p_ctl is the safe word: lrn=1, all other bits 0.
- States and encoding: IDLE=0, CLR_RUN=1, WAIT_VS=2, FRM_RUN=3, BLANK=4, ABORT=5.
- IDLE:
  - en=1 and clr_pend=1 -> CLR_RUN; clr_start pulses in the transition cycle; clr_pend cleared.
  - en=1 and clr_pend=0 -> WAIT_VS.
- CLR_RUN: p_ctl <= c_ctl. On clr_done -> BLANK.
- WAIT_VS: p_ctl = safe.
  - en=0 -> IDLE.
  - clr_pend=1 -> IDLE. A pending clear takes precedence over vsync in the same cycle.
  - vsync rising edge -> FRM_RUN; frm_start pulses in the transition cycle.
- FRM_RUN: p_ctl <= f_ctl. On frm_done -> BLANK.
- BLANK:
  - p_ctl = safe.
  - 0..BLANK_CYC-1 counter; at terminal count -> IDLE, or -> WAIT_VS if en=1 and clr_pend=0.
- ABORT:
  - Entered when the watchdog counter reaches TIMEOUT_CYC in CLR_RUN or FRM_RUN.
  - Sets err, forces p_ctl = safe, sets clr_pend=1, next cycle -> BLANK.
- Watchdog counter: 16-bit; zeroed on each start pulse; increments only in CLR_RUN/FRM_RUN.
- p_ctl timing: the output register samples the mux every cycle, so latency from c_ctl/f_ctl to p_ctl is 1 cycle. The first engine cycle after the start pulse is passed through.
- vsync edge detection: registered vsync_d; edge = vsync & ~vsync_d.
- drop_cnt: a vsync edge in any state other than WAIT_VS increments drop_cnt, saturating at 255.
- clr_req:
  - Sets clr_pend in any state and is never lost.
  - It never interrupts a running frame; it is serviced after the next BLANK.
  - clr_req coincident with the clr_start cycle leaves clr_pend=1, so one further clear pass runs.
- en deassert:
  - A running engine completes normally; no new start is issued; the FSM parks in IDLE.
  - err and drop_cnt are held.
- Stray done pulses: clr_done/frm_done outside their RUN state are ignored.
- busy = (state != IDLE).
- Reset mid-operation: all of the above return to reset values immediately (async). The engines are reset by the same rst_n.

Test Plan:
- Reset, en=1, clr_done 40 cycles after clr_start -> exactly one clr_start; p_ctl tracks c_ctl with 1-cycle lag; 16 safe cycles; state=2.
- In WAIT_VS, vsync edge, frm_done after 100 cycles -> one frm_start; p_ctl=f_ctl delayed 1; BLANK 16 cycles; back to WAIT_VS; drop_cnt=0.
- Three vsync edges during FRM_RUN -> drop_cnt=3. Force 300 edges -> drop_cnt=255.
- clr_req mid-frame -> frame completes, BLANK, then clr_start before the next frm_start, even if vsync arrives during BLANK.
- Withhold frm_done (TIMEOUT_CYC=200) -> ABORT at cycle 200, err=1, p_ctl safe, then BLANK, then a clear pass runs.
- en=0 during CLR_RUN -> clear completes, BLANK, IDLE, busy=0. Assert rst_n=0 mid-FRM_RUN -> p_ctl=safe word immediately.
